// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 output path: digest width, beat counts,
// transmitter state encoding and the ASCII constants used by hex output.
package sha_pkg;

    localparam int unsigned DIGEST_W_DEF = 256;

    // Beats per digest: raw bytes, or hex characters plus a trailing LF.
    localparam int unsigned NBEATS_RAW = DIGEST_W_DEF / 8;
    localparam int unsigned NBEATS_HEX = DIGEST_W_DEF / 4 + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } digest_tx_state_t;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

endpackage

// File: rtl/hex_nibble_enc.sv
// Combinational nibble to lowercase ASCII hex character converter.
// Ports:
//   nib      in  4  value 0..15
//   ascii_c  out 8  '0'..'9' or 'a'..'f'
module hex_nibble_enc
    import sha_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii_c
);

    always_comb begin
        ascii_c = ASCII_0 + 8'(nib);
        if (nib > 4'd9) begin
            ascii_c = ASCII_A_LC + 8'(nib - 4'd10);
        end
    end

endmodule

// File: rtl/digest_tx.sv
// Digest transmitter: captures the final hash on hash_done and streams it out
// MSB-first as bytes over a valid/ready handshake.
// Build option: DIGEST_TX_HEX_EN selects lowercase ASCII hex output with a
// trailing LF (DIGEST_W/4+1 beats); otherwise raw bytes (DIGEST_W/8 beats).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   hash_done   in   one-cycle pulse qualifying fin_hash
//   fin_hash    in   final digest
//   tx_valid    out  tx_data holds a beat
//   tx_ready    in   sink accepts the beat
//   tx_data     out  current output byte
//   busy        out  a digest is held and not fully sent
//   overrun     out  one-cycle pulse: a hash_done was dropped
module digest_tx
    import sha_pkg::*;
#(
    parameter int unsigned DIGEST_W = DIGEST_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hash_done,
    input  logic [DIGEST_W-1:0] fin_hash,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic                overrun
);

`ifdef DIGEST_TX_HEX_EN
    localparam int unsigned NBEATS = DIGEST_W / 4 + 1;
    localparam int unsigned SHIFT  = 4;
`else
    localparam int unsigned NBEATS = DIGEST_W / 8;
    localparam int unsigned SHIFT  = 8;
`endif
    localparam int unsigned        CNT_W = $clog2(NBEATS + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(NBEATS - 1);

    digest_tx_state_t    state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    // Holding register shifts left each beat so the current symbol is on top.
    logic [DIGEST_W-1:0] hold, hold_n;
    logic                ovr_n;
    logic [7:0]          beat_n;
    logic                handshake;
    logic                last_hs;

    assign handshake = tx_valid & tx_ready;
    assign last_hs   = handshake & (cnt == LAST);

    // State and datapath registers; outputs are registered copies of next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hold     <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hold     <= hold_n;
            tx_valid <= (state_n == SEND);
            busy     <= (state_n == SEND);
            tx_data  <= (state_n == SEND) ? beat_n : 8'h00;
            overrun  <= ovr_n;
        end
    end

    // Next-state, beat counter and holding register update.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold;
        ovr_n   = 1'b0;
        case (state)
            IDLE: begin
                if (hash_done) begin
                    hold_n  = fin_hash;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
                    cnt_n = '0;
                    // A digest arriving on the final handshake chains without a gap.
                    if (hash_done) begin
                        hold_n = fin_hash;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        cnt_n  = cnt + CNT_W'(1);
                        hold_n = hold << SHIFT;
                    end
                    ovr_n = hash_done;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Symbol presented for the next beat, derived from the next holding value.
`ifdef DIGEST_TX_HEX_EN
    logic [7:0] nib_ascii_c;

    hex_nibble_enc u_hex_nibble_enc (
        .nib     (hold_n[DIGEST_W-1 -: 4]),
        .ascii_c (nib_ascii_c)
    );

    assign beat_n = (cnt_n == LAST) ? ASCII_LF : nib_ascii_c;
`else
    assign beat_n = hold_n[DIGEST_W-1 -: 8];
`endif

endmodule
